// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data access beats instruction fetch, one transaction
// in flight, pipeline stall/flush generation and a watchdog against a dead bus.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_valid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_be,
  output logic                  d_done,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic                  mem_ready,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushW,
  output logic                  bus_err
);

  localparam bit WD_EN   = (TIMEOUT > 0);
  localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, DATA, IFETCH} state_t;

  state_t             stateReg;
  logic [CNT_W-1:0]   wdCnt;
  logic               dWait;
  logic               fWait;
  logic               busy;
  logic               expire;
  logic               finish;
  logic [DATA_W-1:0]  respData;

  // While a done/valid pulse is showing, the requester has not yet seen it,
  // so its still-high req must not relaunch the same access.
  assign dWait = d_req & ~d_done;
  assign fWait = if_req & ~if_valid;

  assign StallM = dWait;
  assign StallE = dWait;
  assign StallD = dWait;
  assign StallF = dWait | fWait;
  assign FlushD = fWait & ~dWait;
  assign FlushW = dWait;

  // The TIMEOUT-th busy cycle without mem_ready completes the access as if ready.
  assign busy     = (stateReg != IDLE);
  assign expire   = WD_EN && busy && !mem_ready && (wdCnt == CNT_W'(TO_LAST));
  assign finish   = busy && (mem_ready || expire);
  assign respData = expire ? '0 : mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg  <= IDLE;
      wdCnt     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      d_done    <= 1'b0;
      d_rdata   <= '0;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      bus_err   <= 1'b0;
    end else begin
      d_done   <= 1'b0;
      if_valid <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (dWait) begin
            stateReg  <= DATA;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
            wdCnt     <= '0;
          end else if (fWait) begin
            stateReg  <= IFETCH;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_be    <= '1;
            wdCnt     <= '0;
          end
        end
        DATA, IFETCH: begin
          if (finish) begin
            stateReg <= IDLE;
            mem_req  <= 1'b0;
            if (expire) bus_err <= 1'b1;
            // A requester that dropped its req was flushed: finish silently.
            if (stateReg == DATA && d_req) begin
              d_done <= 1'b1;
              if (!mem_we) d_rdata <= respData;
            end
            if (stateReg == IFETCH && if_req) begin
              if_valid <= 1'b1;
              if_rdata <= respData;
            end
          end else if (WD_EN) begin
            wdCnt <= wdCnt + CNT_W'(1);
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level reference model checked
// every cycle, plus literal expectations for each directed scenario.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_valid;
  logic [DW-1:0]   if_rdata;
  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_be;
  logic            d_done;
  logic [DW-1:0]   d_rdata;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic            mem_ready;
  logic [DW-1:0]   mem_rdata;
  logic            StallF, StallD, StallE, StallM, FlushD, FlushW;
  logic            bus_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushW(FlushW), .bus_err(bus_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: ready on the (respLat+1)-th cycle of mem_req, or never.
  int        respLat = 0;
  bit        respNever = 1'b0;
  bit        readyForce = 1'b0;
  logic      respReady = 1'b0;
  logic [DW-1:0] respData = '0;
  int        reqCycles = 0;

  assign mem_ready = respReady | readyForce;

  always @(negedge clk) begin
    if (mem_req && !respNever) begin
      reqCycles++;
      if (reqCycles == respLat + 1) begin
        respReady = 1'b1;
        mem_rdata = respData;
      end else begin
        respReady = 1'b0;
      end
    end else begin
      if (!mem_req) reqCycles = 0;
      respReady = 1'b0;
      mem_rdata = readyForce ? respData : '0;
    end
  end

  // Reference model: one outstanding transaction record plus the pulses it produces.
  logic            mBusy, mIsData, mWe, mDone, mValid, mBusErr;
  logic [AW-1:0]   mAddr;
  logic [DW-1:0]   mWdata, mDrd, mIrd;
  logic [DW/8-1:0] mBe;
  int              mAge;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mBusy <= 0; mIsData <= 0; mWe <= 0; mDone <= 0; mValid <= 0; mBusErr <= 0;
      mAddr <= '0; mWdata <= '0; mDrd <= '0; mIrd <= '0; mBe <= '0; mAge <= 0;
    end else begin
      mDone  <= 1'b0;
      mValid <= 1'b0;
      if (!mBusy) begin
        if (d_req && !mDone) begin
          mBusy <= 1; mIsData <= 1; mWe <= d_we; mAddr <= d_addr;
          mWdata <= d_wdata; mBe <= d_be; mAge <= 0;
        end else if (if_req && !mValid) begin
          mBusy <= 1; mIsData <= 0; mWe <= 0; mAddr <= if_addr; mAge <= 0;
        end
      end else if (mem_ready || mAge == TO - 1) begin
        mBusy <= 1'b0;
        if (!mem_ready) mBusErr <= 1'b1;
        if (mIsData && d_req) begin
          mDone <= 1'b1;
          if (!mWe) mDrd <= mem_ready ? mem_rdata : '0;
        end
        if (!mIsData && if_req) begin
          mValid <= 1'b1;
          mIrd   <= mem_ready ? mem_rdata : '0;
        end
      end else begin
        mAge <= mAge + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic dw, fw;
    #1;
    dw = d_req & ~mDone;
    fw = if_req & ~mValid;
    chk("m_d_done", d_done, mDone);
    chk("m_if_valid", if_valid, mValid);
    chk("m_d_rdata", d_rdata, mDrd);
    chk("m_if_rdata", if_rdata, mIrd);
    chk("m_mem_req", mem_req, mBusy);
    chk("m_bus_err", bus_err, mBusErr);
    chk("m_stalls", {StallF, StallD, StallE, StallM, FlushD, FlushW},
        {dw | fw, dw, dw, dw, fw & ~dw, dw});
    if (mBusy) begin
      chk("m_mem_addr", mem_addr, mAddr);
      chk("m_mem_we", mem_we, mWe);
      if (mIsData) begin
        chk("m_mem_wdata", mem_wdata, mWdata);
        chk("m_mem_be", mem_be, mBe);
      end
    end
  end

  task automatic waitPulse(input bit wantData, input int maxCyc, input int expCyc,
                           input string name);
    int cyc = 0;
    bit seen = 1'b0;
    while (!seen && cyc < maxCyc) begin
      @(negedge clk);
      cyc++;
      seen = wantData ? d_done : if_valid;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: no pulse within %0d cycles", name, maxCyc);
    end else begin
      chk({name, "_latency"}, cyc, expCyc);
    end
  endtask

  initial begin
    bit doneSeen;
    reset = 1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; d_be = '0; mem_rdata = '0;
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_d_done", d_done, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_stallF", StallF, 0);
    reset = 0;

    // 1: plain fetch, ready two cycles after mem_req rises
    @(negedge clk);
    if_req = 1; if_addr = 32'h100; respLat = 2; respData = 32'hCAFE0001;
    #1;
    chk("t1_stallF", StallF, 1);
    chk("t1_flushD", FlushD, 1);
    chk("t1_stallD", StallD, 0);
    @(negedge clk);
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    waitPulse(0, 10, 3, "t1_valid");
    chk("t1_if_rdata", if_rdata, 32'hCAFE0001);
    chk("t1_stallF_pulse", StallF, 0);
    if_req = 0;

    // 2: simultaneous requests, data first then fetch
    @(negedge clk);
    d_req = 1; d_we = 0; d_addr = 32'h2000; if_req = 1; if_addr = 32'h104;
    respLat = 0; respData = 32'h12345678;
    #1;
    chk("t2_stallM", StallM, 1);
    chk("t2_stallF", StallF, 1);
    chk("t2_flushW", FlushW, 1);
    chk("t2_flushD", FlushD, 0);
    waitPulse(1, 10, 2, "t2_done");
    chk("t2_d_rdata", d_rdata, 32'h12345678);
    d_req = 0; respData = 32'h0BADF00D;
    @(negedge clk);
    chk("t2_fetch_req", mem_req, 1);
    chk("t2_fetch_addr", mem_addr, 32'h104);
    waitPulse(0, 10, 1, "t2_valid");
    chk("t2_if_rdata", if_rdata, 32'h0BADF00D);
    if_req = 0;

    // 3: store, ready on the last cycle before the watchdog would fire
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
    respLat = 3; respData = 32'hFFFFFFFF;
    @(negedge clk);
    chk("t3_mem_we", mem_we, 1);
    chk("t3_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("t3_mem_be", mem_be, 4'hF);
    chk("t3_mem_addr", mem_addr, 32'h40);
    waitPulse(1, 10, 4, "t3_done");
    chk("t3_d_rdata_held", d_rdata, 32'h12345678);
    chk("t3_bus_err", bus_err, 0);
    d_req = 0; d_we = 0;

    // 4: dead bus, forced completion, sticky error
    @(negedge clk);
    d_req = 1; d_addr = 32'h80; respNever = 1;
    waitPulse(1, 12, 5, "t4_done");
    chk("t4_d_rdata", d_rdata, 0);
    chk("t4_bus_err", bus_err, 1);
    d_req = 0; respNever = 0;
    @(negedge clk);
    if_req = 1; if_addr = 32'h200; respLat = 0; respData = 32'h11112222;
    waitPulse(0, 10, 2, "t4_fetch");
    chk("t4_if_rdata", if_rdata, 32'h11112222);
    chk("t4_bus_err_sticky", bus_err, 1);
    if_req = 0;

    // 5: asynchronous reset in the middle of a data access
    @(negedge clk);
    d_req = 1; d_addr = 32'h300; respNever = 1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_busy", mem_req, 1);
    #3;
    reset = 1; d_req = 0;
    #1;
    chk("t5_mem_req", mem_req, 0);
    chk("t5_bus_err", bus_err, 0);
    chk("t5_d_rdata", d_rdata, 0);
    chk("t5_if_rdata", if_rdata, 0);
    chk("t5_stallM", StallM, 0);
    @(negedge clk);
    reset = 0; respNever = 0;

    // 6: data requester flushed mid-access, then a stray ready while idle
    @(negedge clk);
    d_req = 1; d_we = 0; d_addr = 32'h500; respLat = 2; respData = 32'h77777777;
    @(negedge clk);
    @(negedge clk);
    d_req = 0;
    chk("t6_held", mem_req, 1);
    @(negedge clk);
    chk("t6_held_ready", mem_req, 1);
    doneSeen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (d_done) doneSeen = 1'b1;
    end
    chk("t6_no_done", doneSeen, 0);
    chk("t6_released", mem_req, 0);
    chk("t6_d_rdata", d_rdata, 0);
    respData = 32'h55;
    readyForce = 1;
    @(negedge clk);
    readyForce = 0;
    @(negedge clk);
    chk("t6_idle_ready_req", mem_req, 0);
    chk("t6_idle_ready_done", d_done, 0);
    chk("t6_idle_ready_err", bus_err, 0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
